cache_ctrl_4way: RTL
====================

// Module: cache_ctrl_4way
// PURPOSE
//  Control FSM for a 4-way set-associative, write-back/write-allocate data cache.
//  Requester of the per-set PLRU array: drives set index, hit strobe and hit way; consumes the victim way.
//  Sits between the CPU load/store port (ufp_*) and the line-granular memory port (dfp_*).
//  Holds tag/valid/dirty metadata and line data in flops.
// PARAMETERS
//  SETS        16   number of sets; INDEX_W = $clog2(SETS) = 4
//  WAYS        4    associativity; fixed at 4 to match the 2-bit PLRU way encoding
//  LINE_BITS   256  line size in bits (32 bytes); OFFSET_W = 5
//  ADDR_W      32   byte address width; TAG_W = ADDR_W - INDEX_W - OFFSET_W = 23
// PORTS
//  clk           in   1         clock
//  rst           in   1         reset, synchronous, active-low
//  ufp_addr      in   ADDR_W    CPU byte address; addr[1:0] ignored
//  ufp_rmask     in   4         read byte mask; nonzero = read request
//  ufp_wmask     in   4         write byte mask; nonzero = write request
//  ufp_wdata     in   32        write data
//  ufp_rdata     out  32        read word, valid when ufp_resp=1
//  ufp_resp      out  1         one-cycle completion pulse
//  dfp_addr      out  ADDR_W    line-aligned memory address; [4:0] always 0
//  dfp_read      out  1         line fill request; held until dfp_resp
//  dfp_write     out  1         line writeback request; held until dfp_resp
//  dfp_wdata     out  LINE_BITS writeback line
//  dfp_rdata     in   LINE_BITS fill line, valid with dfp_resp
//  dfp_resp      in   1         memory completion pulse
//  plru_index    out  INDEX_W   set index presented to the PLRU array
//  plru_hit      out  1         one-cycle pulse: access hit in plru_hit_way
//  plru_hit_way  out  2         way that hit
//  plru_replace  in   2         PLRU victim way for plru_index
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; all valid/dirty bits=0; ufp_resp, dfp_read, dfp_write, plru_hit=0;
//   ufp_rdata, dfp_addr, plru_index, plru_hit_way=0. Tags/data not reset.
//  Mid-operation reset abandons any transfer; dfp_read/dfp_write fall the following cycle; a late dfp_resp is ignored.
//  States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
//  IDLE: if (rmask|wmask)!=0, latch addr/masks/wdata -> COMPARE. Inputs are ignored in every other state.
//  COMPARE: hit = valid & tag match in any way (at most one).
//   Hit: ufp_resp=1 this cycle; ufp_rdata = word addr[4:2] of the line, pre-write value.
//    Write: merge wdata bytes per wmask and set dirty. plru_hit=1, plru_hit_way=hit way. -> IDLE.
//    Hit latency = 2 cycles, request cycle to ufp_resp.
//   Miss: victim = lowest-numbered invalid way, else plru_replace; latch victim.
//    victim valid&dirty -> WRITEBACK, else -> ALLOCATE. No resp and no plru_hit on a miss.
//  WRITEBACK: dfp_write=1, dfp_addr={victim tag, index, 5'b0}, dfp_wdata=victim line.
//   On dfp_resp: clear dirty, -> ALLOCATE.
//  ALLOCATE: dfp_read=1, dfp_addr={req tag, index, 5'b0}.
//   On dfp_resp: line <= dfp_rdata, tag <= req tag, valid=1, dirty=0, -> COMPARE. The re-compare hits.
//  plru_index = latched request index in every state, so plru_replace is valid in COMPARE.
//  rmask and wmask both nonzero: treated as a write; ufp_rdata returns the pre-write word.
//  dfp_read and dfp_write are never both 1. dfp_resp in IDLE or COMPARE is ignored.
//  One request is outstanding at a time; the CPU holds no request while awaiting ufp_resp.
// STRUCTURE
//  cache_pkg: INDEX_W, OFFSET_W, TAG_W, LINE_BITS, typedef enum cache_state_t, typedef line_t,
//   typedef struct meta_t {tag, valid, dirty}.
//  Sub-module cache_meta_array: SETS x WAYS meta_t storage, 1 write port, combinational read of all ways of a set.
//  Data lines, FSM and victim select stay in cache_ctrl_4way.
//  Top-level wiring instantiates plru_array beside this block.
// TESTING (bench models plru_array and memory with 3-cycle dfp_resp)
//  1 Reset, read 0x0000_0040 -> ALLOCATE fill of 0x40, dfp_read 3 cycles, ufp_resp 2 cycles after fill,
//    ufp_rdata = fill word 0; plru_hit=1, plru_hit_way=0, plru_index=2.
//  2 Write 0xDEADBEEF wmask=4'b0011 to 0x44 then read 0x44 -> rdata low half 0xBEEF, upper bytes unchanged;
//    hit latency 2, no dfp activity.
//  3 Fill ways 0-3 of set 2 (0x040, 0x240, 0x440, 0x640); read 0x840 with plru_replace=1 -> way 1 refilled,
//    no writeback when way 1 is clean.
//  4 Dirty way 1 first, repeat test 3 -> dfp_write with dfp_addr=0x240 and the dirty line data, then dfp_read 0x840.
//    dfp_read never overlaps dfp_write.
//  5 Assert rst=0 during WRITEBACK -> dfp_write=0 the next cycle, all lines invalid, next read of 0x240 misses.
//  6 Invalid way present (way 3 invalid) with plru_replace=0 -> way 3 chosen; stray dfp_resp in IDLE has no effect.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, state and metadata types for the 4-way data cache
package cache_pkg;
  localparam int SETS      = 16;
  localparam int WAYS      = 4;
  localparam int ADDR_W    = 32;
  localparam int LINE_BITS = 256;
  localparam int INDEX_W   = $clog2(SETS);
  localparam int OFFSET_W  = 5;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int META_W    = TAG_W + 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} cache_state_t;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
    logic             dirty;
  } meta_t;
endpackage

// File: rtl/cache_meta_array.sv
// rtl/cache_meta_array.sv - per-set tag/valid/dirty storage, one write port, all ways read at once
module cache_meta_array
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [INDEX_W-1:0]     windex,
  input  logic [1:0]             wway,
  input  logic [META_W-1:0]      wmeta,
  input  logic [INDEX_W-1:0]     rindex,
  output logic [WAYS*META_W-1:0] rmeta
);
  meta_t meta_q [SETS][WAYS];

  // Only valid/dirty are cleared; tags are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta_q[s][w].valid <= 1'b0;
          meta_q[s][w].dirty <= 1'b0;
        end
      end
    end else if (we) begin
      meta_q[windex][wway] <= meta_t'(wmeta);
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_rd
    assign rmeta[w*META_W +: META_W] = meta_q[rindex][w];
  end
endmodule

// File: rtl/cache_ctrl_4way.sv
// rtl/cache_ctrl_4way.sv - write-back/write-allocate 4-way cache controller with PLRU victim input
module cache_ctrl_4way
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  input  logic [31:0]          ufp_wdata,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  output logic [ADDR_W-1:0]    dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp,
  output logic [INDEX_W-1:0]   plru_index,
  output logic                 plru_hit,
  output logic [1:0]           plru_hit_way,
  input  logic [1:0]           plru_replace
);
  cache_state_t        state_q, state_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          victim_q, victim_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                resp_q, resp_d, dread_q, dread_d, dwrite_q, dwrite_d, phit_q, phit_d;
  logic [1:0]          hway_q, hway_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  line_t               data_q [SETS][WAYS];

  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_W-1:0]      req_index;
  logic [2:0]              req_word;
  logic [WAYS*META_W-1:0]  rmeta;
  meta_t                   way_meta [WAYS];
  logic                    meta_we, data_we, hit, inv_found;
  logic [1:0]              meta_wway, data_wway, hit_way, inv_way, miss_way;
  meta_t                   meta_wdata;
  line_t                   hit_line, merged, data_wline;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^ufp_addr[1:0];
  assign req_tag   = addr_q[ADDR_W-1:OFFSET_W+INDEX_W];
  assign req_index = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_word  = addr_q[OFFSET_W-1:2];

  cache_meta_array u_meta (
    .clk    (clk),
    .rst    (rst),
    .we     (meta_we),
    .windex (req_index),
    .wway   (meta_wway),
    .wmeta  (meta_wdata),
    .rindex (req_index),
    .rmeta  (rmeta)
  );

  for (genvar w = 0; w < WAYS; w++) begin : g_unpack
    assign way_meta[w] = meta_t'(rmeta[w*META_W +: META_W]);
  end

  // Scan downwards so the lowest-numbered invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = 2'd0;
    inv_found = 1'b0;
    inv_way   = 2'd0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (way_meta[w].valid && way_meta[w].tag == req_tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (!way_meta[w].valid) begin
        inv_found = 1'b1;
        inv_way   = 2'(w);
      end
    end
  end

  assign miss_way  = inv_found ? inv_way : plru_replace;
  assign hit_line  = data_q[req_index][hit_way];
  assign dfp_wdata = data_q[req_index][victim_q];

  always_comb begin
    merged = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (wmask_q[b]) merged[int'(req_word)*32 + b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    rdata_d    = rdata_q;
    resp_d     = 1'b0;
    phit_d     = 1'b0;
    hway_d     = hway_q;
    dread_d    = dread_q;
    dwrite_d   = dwrite_q;
    daddr_d    = daddr_q;
    meta_we    = 1'b0;
    meta_wway  = hit_way;
    meta_wdata = '{tag: req_tag, valid: 1'b1, dirty: 1'b1};
    data_we    = 1'b0;
    data_wway  = hit_way;
    data_wline = merged;
    case (state_q)
      IDLE: begin
        if (|(ufp_rmask | ufp_wmask)) begin
          addr_d  = ufp_addr[ADDR_W-1:2];
          wmask_d = ufp_wmask;
          wdata_d = ufp_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          resp_d  = 1'b1;
          rdata_d = hit_line[int'(req_word)*32 +: 32];
          phit_d  = 1'b1;
          hway_d  = hit_way;
          state_d = IDLE;
          if (|wmask_q) begin
            meta_we = 1'b1;
            data_we = 1'b1;
          end
        end else begin
          victim_d = miss_way;
          if (way_meta[miss_way].valid && way_meta[miss_way].dirty) begin
            dwrite_d = 1'b1;
            daddr_d  = {way_meta[miss_way].tag, req_index, 5'b0};
            state_d  = WRITEBACK;
          end else begin
            dread_d = 1'b1;
            daddr_d = {req_tag, req_index, 5'b0};
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (dfp_resp) begin
          meta_we    = 1'b1;
          meta_wway  = victim_q;
          meta_wdata = '{tag: way_meta[victim_q].tag, valid: 1'b1, dirty: 1'b0};
          dwrite_d   = 1'b0;
          dread_d    = 1'b1;
          daddr_d    = {req_tag, req_index, 5'b0};
          state_d    = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (dfp_resp) begin
          meta_we    = 1'b1;
          meta_wway  = victim_q;
          meta_wdata = '{tag: req_tag, valid: 1'b1, dirty: 1'b0};
          data_we    = 1'b1;
          data_wway  = victim_q;
          data_wline = dfp_rdata;
          dread_d    = 1'b0;
          state_d    = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
      phit_q   <= 1'b0;
      hway_q   <= '0;
      dread_q  <= 1'b0;
      dwrite_q <= 1'b0;
      daddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      phit_q   <= phit_d;
      hway_q   <= hway_d;
      dread_q  <= dread_d;
      dwrite_q <= dwrite_d;
      daddr_q  <= daddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && data_we) data_q[req_index][data_wway] <= data_wline;
  end

  assign ufp_rdata    = rdata_q;
  assign ufp_resp     = resp_q;
  assign dfp_addr     = daddr_q;
  assign dfp_read     = dread_q;
  assign dfp_write    = dwrite_q;
  assign plru_index   = req_index;
  assign plru_hit     = phit_q;
  assign plru_hit_way = hway_q;
endmodule
